// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - types and constants shared by the UART receiver and transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_DIV_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - multi-flop synchronizer for an asynchronous input, resets to 1 (line idle).
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '1;
    end else begin
      chain <= {chain[STAGES-2:0], din};
    end
  end

  assign dout = chain[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with a one-byte valid/ready holding register.
// Define UART_RX_ERR_EN to check the stop bit and drive the frame_err_o/overrun_o pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DIV_W       = UART_DIV_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      rx_en_i,
  input  logic                      rx_i,
  input  logic [DIV_W-1:0]          baud_div_i,
  output logic [UART_DATA_BITS-1:0] data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      busy_o,
  output logic                      frame_err_o,
  output logic                      overrun_o
);

  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(UART_DATA_BITS - 1);

  rx_state_t                 state_q, state_d;
  logic [DIV_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      rx_s;
  logic                      stop_sample;
  logic                      stop_ok;
  logic                      deliver;

  uart_sync #(
    .STAGES(SYNC_STAGES)
  ) u_rx_sync (
    .clk (clk_i),
    .rst (rst_i),
    .din (rx_i),
    .dout(rx_s)
  );

  // Bit timing: the start bit is checked at its midpoint, after which every
  // full bit period lands on the middle of the next bit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    stop_sample = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_en_i && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == (baud_div_i >> 1)) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == baud_div_i) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == baud_div_i) begin
          cnt_d       = '0;
          state_d     = IDLE;
          stop_sample = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_RX_ERR_EN
  assign stop_ok = rx_s;
`else
  assign stop_ok = 1'b1;
`endif

  // A completed byte may replace the held one in the same cycle it is consumed.
  assign deliver = stop_sample && stop_ok && (!valid_q || ready_i);

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (deliver) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

`ifdef UART_RX_ERR_EN
  logic frame_err_q;
  logic overrun_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= stop_sample && !rx_s;
      overrun_q   <= stop_sample && rx_s && valid_q && !ready_i;
    end
  end

  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
`else
  assign frame_err_o = 1'b0;
  assign overrun_o   = 1'b0;
`endif

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver: directed cases plus random frames
// against a frame-level reference (expected byte queue, latency formula, error pulse counts).
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int DIV_W = 16;
  localparam int SYNC  = 2;
`ifdef UART_RX_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk   = 1'b0;
  logic             rst   = 1'b1;
  logic             rx_en = 1'b1;
  logic             rx    = 1'b1;
  logic             ready = 1'b1;
  logic [DIV_W-1:0] baud  = 16'd3;
  logic [7:0]       data;
  logic             valid, busy, frame_err, overrun;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  int exp_ferr = 0, exp_ovr = 0, seen_ferr = 0, seen_ovr = 0;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t exp_q[$];

  uart_receiver #(
    .DIV_W      (DIV_W),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_en_i    (rx_en),
    .rx_i       (rx),
    .baud_div_i (baud),
    .data_o     (data),
    .valid_o    (valid),
    .ready_i    (ready),
    .busy_o     (busy),
    .frame_err_o(frame_err),
    .overrun_o  (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Clocks from driving the start bit low until valid_o is first seen high:
  // synchronizer, start detection, half a bit, nine bit periods, output register.
  function automatic int frame_lat(input int b);
    return SYNC + 2 + (b / 2) + 9 * (b + 1);
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit deliver, input bit timed);
    exp_t       e;
    int         p;
    logic [9:0] bits;
    p    = int'(baud) + 1;
    bits = {stop_bit, d, 1'b0};
    @(negedge clk);
    e.data = d;
    e.due  = timed ? cyc + frame_lat(int'(baud)) : -1;
    if (deliver) exp_q.push_back(e);
    if (!stop_bit && ERR_EN) exp_ferr++;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (p) @(negedge clk);
    end
    rx = 1'b1;
    repeat (stop_bit ? p + 2 : 2 * p + 4) @(negedge clk);
  endtask

  always @(negedge clk) begin
    #1;
    if (frame_err) seen_ferr++;
    if (overrun) seen_ovr++;
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rx_data", {24'd0, data}, {24'd0, e.data});
        if (e.due >= 0) check("rx_latency", cyc, e.due);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    @(negedge clk);

    baud = 16'd3;
    ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    check("a5_drained", exp_q.size(), 0);
    check("a5_valid_low", valid, 0);
    check("a5_no_err", seen_ferr + seen_ovr, 0);

    baud = 16'd15;
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy_high", busy, 1);
    repeat (12) @(negedge clk);
    check("glitch_busy_low", busy, 0);
    check("glitch_valid", valid, 0);

    baud = 16'd7;
    send_frame(8'h3C, 1'b0, !ERR_EN, 1'b1);
    check("bad_stop_ferr", seen_ferr, ERR_EN ? 1 : 0);
    check("bad_stop_data", data, ERR_EN ? 8'hA5 : 8'h3C);

    baud = 16'd3;
    ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    if (ERR_EN) exp_ovr++;
    check("ovr_data", data, 8'h11);
    check("ovr_valid", valid, 1);
    check("ovr_pulse", seen_ovr, exp_ovr);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("ovr_cleared", valid, 0);

    send_frame(8'h44, 1'b1, 1'b1, 1'b0);
    fork
      send_frame(8'h55, 1'b1, 1'b1, 1'b0);
      begin
        @(negedge clk);
        repeat (frame_lat(3) - 1) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        check("fill_data", data, 8'h55);
        check("fill_valid", valid, 1);
        ready = 1'b0;
      end
    join
    check("fill_no_ovr", seen_ovr, exp_ovr);

    baud = 16'd7;
    fork
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
      begin
        repeat (40) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", valid, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_busy", busy, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
      end
    join
    ready = 1'b1;
    send_frame(8'h81, 1'b1, 1'b1, 1'b1);
    check("post_rst_data", data, 8'h81);

    rx_en = 1'b0;
    send_frame(8'h99, 1'b1, 1'b0, 1'b0);
    rx_en = 1'b1;
    check("disabled_data", data, 8'h81);

    for (int k = 0; k < 40; k++) begin
      logic [7:0] d;
      bit         sb;
      int         gap;
      d    = 8'($urandom);
      sb   = ($urandom_range(0, 4) != 0);
      baud = DIV_W'($urandom_range(2, 12));
      gap  = $urandom_range(0, 5);
      fork
        send_frame(d, sb, sb || !ERR_EN, 1'b1);
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(5, 30)) @(negedge clk);
          rx_en = 1'b0;
        end
      join
      rx_en = 1'b1;
      repeat (gap) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    check("final_pending", exp_q.size(), 0);
    check("final_frame_err", seen_ferr, exp_ferr);
    check("final_overrun", seen_ovr, exp_ovr);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
